// File: rtl/add_share_arbiter.sv
// add_share_arbiter: lets two requesters (e.g. PC+4 incrementer and branch
// target unit) time-share one external WIDTH-bit adder. Each requester uses a
// valid/ready handshake. The granted operands are registered onto
// add_in1/add_in2, and the adder result is captured into a response register
// that holds until the consumer takes it.
//
// Build option: define ADD_OVF_DETECT_EN to produce a signed-overflow flag on
// rsp_overflow. When it is not defined, rsp_overflow is tied to 0.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for a request; the granted requester sees ready
// EXEC  | operands sit on the adder; capture the sum at the end of the cycle
// HOLD  | response is presented; wait for rsp_ready, then update RR pointer

module add_share_arbiter #(
  parameter int WIDTH   = 32,
  parameter int PRIO_RR = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic [WIDTH-1:0] add_in1,
  output logic [WIDTH-1:0] add_in2,
  input  logic [WIDTH-1:0] add_sum,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_overflow,
  input  logic             rsp_ready,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0] state;
  logic       rr_ptr;
  logic       grant_any;
  logic       grant_id;
  logic       accept;

  // Choose which requester wins the IDLE slot. When both requesters are
  // valid, the policy decides. The pointer is kept up to date in both policy
  // modes; fixed priority simply does not look at it.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = (PRIO_RR != 0) ? rr_ptr : 1'b0;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  // Ready goes only to the granted requester, only in IDLE, and never
  // during reset.
  always_comb begin
    accept     = (state == S_IDLE) && !reset && grant_any;
    req0_ready = accept && (grant_id == 1'b0);
    req1_ready = accept && (grant_id == 1'b1);
  end

  assign busy = (state != S_IDLE);

  // Main sequencer: capture operands, latch the sum, and hold the response
  // until it is consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      rr_ptr    <= 1'b0;
      add_in1   <= '0;
      add_in2   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_sum   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            add_in1 <= grant_id ? req1_a : req0_a;
            add_in2 <= grant_id ? req1_b : req0_b;
            rsp_id  <= grant_id;
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_sum   <= add_sum;
          rsp_valid <= 1'b1;
          state     <= S_HOLD;
        end
        S_HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= ~rsp_id;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ADD_OVF_DETECT_EN
  // Signed overflow: the operands have the same sign, but the sum's sign
  // differs from it. The flag is sampled together with the sum in EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_overflow <= 1'b0;
    end else if (state == S_EXEC) begin
      rsp_overflow <= (add_in1[WIDTH-1] == add_in2[WIDTH-1]) &&
                      (add_sum[WIDTH-1] != add_in1[WIDTH-1]);
    end
  end
`else
  assign rsp_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_add_share_arbiter.sv
// Bench for add_share_arbiter. A round-robin instance and a fixed-priority
// instance share the same stimulus, and each one has its own behavioural
// adder.

module tb_add_share_arbiter;

`ifdef ADD_OVF_DETECT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_ready;

  logic        r_req0_ready, r_req1_ready, r_rsp_valid, r_rsp_id, r_rsp_ovf, r_busy;
  logic [31:0] r_add_in1, r_add_in2, r_add_sum, r_rsp_sum;
  logic        f_req0_ready, f_req1_ready, f_rsp_valid, f_rsp_id, f_rsp_ovf, f_busy;
  logic [31:0] f_add_in1, f_add_in2, f_add_sum, f_rsp_sum;

  assign r_add_sum = r_add_in1 + r_add_in2;
  assign f_add_sum = f_add_in1 + f_add_in2;

  always #5 clk = ~clk;

  add_share_arbiter #(.WIDTH(32), .PRIO_RR(1)) dut_rr (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(r_req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(r_req1_ready),
    .add_in1(r_add_in1), .add_in2(r_add_in2), .add_sum(r_add_sum),
    .rsp_valid(r_rsp_valid), .rsp_id(r_rsp_id), .rsp_sum(r_rsp_sum),
    .rsp_overflow(r_rsp_ovf), .rsp_ready(rsp_ready), .busy(r_busy)
  );

  add_share_arbiter #(.WIDTH(32), .PRIO_RR(0)) dut_fp (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(f_req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(f_req1_ready),
    .add_in1(f_add_in1), .add_in2(f_add_in2), .add_sum(f_add_sum),
    .rsp_valid(f_rsp_valid), .rsp_id(f_rsp_id), .rsp_sum(f_rsp_sum),
    .rsp_overflow(f_rsp_ovf), .rsp_ready(rsp_ready), .busy(f_busy)
  );

  typedef struct {
    logic        v0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic        v1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic        exp_id;
    logic [31:0] exp_sum;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [9];
  int   checks = 0;
  int   errors = 0;
  bit   in_contention = 1'b0;
  int   fp_req1_seen = 0;

  // Watch the fixed-priority instance while both requesters compete.
  always @(posedge clk) begin
    if (in_contention && f_req1_ready) fp_req1_seen++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issue one vector from IDLE, follow it through EXEC and HOLD, and return
  // at the negedge where the arbiter is back in IDLE.
  task automatic run_vec(input vec_t v);
    bit   accepted;
    logic exp_fp_id;
    logic [31:0] exp_fp_sum;
    exp_fp_id  = v.v0 ? 1'b0 : 1'b1;
    exp_fp_sum = v.v0 ? (v.a0 + v.b0) : (v.a1 + v.b1);
    req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0;
    req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1;
    accepted = 1'b0;
    for (int i = 0; i < 10 && !accepted; i++) begin
      #1;
      if ((req0_valid && r_req0_ready) || (req1_valid && r_req1_ready)) accepted = 1'b1;
      else @(negedge clk);
    end
    if (!accepted) begin
      chk("accept_timeout", 32'd0, 32'd1);
      return;
    end
    chk("grant_rr", {31'd0, r_req1_ready}, {31'd0, v.exp_id});
    chk("grant_fp", {31'd0, f_req1_ready}, {31'd0, exp_fp_id});
    @(negedge clk);
    chk("exec_busy", {31'd0, r_busy}, 32'd1);
    chk("exec_rsp_valid", {31'd0, r_rsp_valid}, 32'd0);
    chk("exec_ready", {30'd0, r_req0_ready, r_req1_ready}, 32'd0);
    @(negedge clk);
    chk("hold_rsp_valid", {31'd0, r_rsp_valid}, 32'd1);
    chk("hold_rsp_id", {31'd0, r_rsp_id}, {31'd0, v.exp_id});
    chk("hold_rsp_sum", r_rsp_sum, v.exp_sum);
    chk("hold_rsp_ovf", {31'd0, r_rsp_ovf}, {31'd0, v.exp_ovf & OVF_EN});
    chk("fp_rsp_id", {31'd0, f_rsp_id}, {31'd0, exp_fp_id});
    chk("fp_rsp_sum", f_rsp_sum, exp_fp_sum);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("done_rsp_valid", {31'd0, r_rsp_valid}, 32'd0);
    chk("done_busy", {31'd0, r_busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 32'd5,          32'd7,          1'b0, 32'd0,          32'd0,          1'b0, 32'd12,         1'b0};
    vecs[1] = '{1'b0, 32'd0,          32'd0,          1'b1, 32'hFFFF_FFFF,  32'd1,          1'b1, 32'h0000_0000,  1'b0};
    vecs[2] = '{1'b1, 32'h7FFF_FFFF,  32'd1,          1'b0, 32'd0,          32'd0,          1'b0, 32'h8000_0000,  1'b1};
    vecs[3] = '{1'b0, 32'd0,          32'd0,          1'b1, 32'h8000_0000,  32'h8000_0000,  1'b1, 32'h0000_0000,  1'b1};
    vecs[4] = '{1'b0, 32'd0,          32'd0,          1'b1, 32'h8000_0000,  32'h7FFF_FFFF,  1'b1, 32'hFFFF_FFFF,  1'b0};
    vecs[5] = '{1'b1, 32'd1,          32'd2,          1'b1, 32'd10,         32'd20,         1'b0, 32'd3,          1'b0};
    vecs[6] = '{1'b1, 32'd1,          32'd2,          1'b1, 32'd10,         32'd20,         1'b1, 32'd30,         1'b0};
    vecs[7] = '{1'b1, 32'd1,          32'd2,          1'b1, 32'd10,         32'd20,         1'b0, 32'd3,          1'b0};
    vecs[8] = '{1'b1, 32'd1,          32'd2,          1'b1, 32'd10,         32'd20,         1'b1, 32'd30,         1'b0};

    // Reset: ready must stay low even while both requesters are valid.
    reset = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9;
    req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd9;
    @(negedge clk); @(negedge clk);
    chk("rst_ready", {30'd0, r_req0_ready, r_req1_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, r_rsp_valid}, 32'd0);
    chk("rst_rsp_id", {31'd0, r_rsp_id}, 32'd0);
    chk("rst_rsp_sum", r_rsp_sum, 32'd0);
    chk("rst_rsp_ovf", {31'd0, r_rsp_ovf}, 32'd0);
    chk("rst_add_in1", r_add_in1, 32'd0);
    chk("rst_add_in2", r_add_in2, 32'd0);
    chk("rst_busy", {31'd0, r_busy}, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    // Vector table. Vectors 5 to 8 are continuous contention.
    for (int k = 0; k < 9; k++) begin
      if (k == 5) in_contention = 1'b1;
      run_vec(vecs[k]);
    end
    in_contention = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("fp_req1_never_ready", fp_req1_seen, 32'd0);
    @(negedge clk);

    // Backpressure, with rsp_ready also pulsed while in EXEC.
    req0_valid = 1'b1; req0_a = 32'd40; req0_b = 32'd2;
    #1;
    chk("bp_req0_ready", {31'd0, r_req0_ready}, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_exec_ready_ignored", {31'd0, r_rsp_valid}, 32'd1);
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 32'h11; req1_b = 32'h22;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", {31'd0, r_rsp_valid}, 32'd1);
      chk("bp_hold_sum", r_rsp_sum, 32'd42);
      chk("bp_hold_id", {31'd0, r_rsp_id}, 32'd0);
      chk("bp_req1_ready", {31'd0, r_req1_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("bp_idle_valid", {31'd0, r_rsp_valid}, 32'd0);
    chk("bp_req1_granted", {31'd0, r_req1_ready}, 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    chk("bp_req1_sum", r_rsp_sum, 32'h33);
    chk("bp_req1_id", {31'd0, r_rsp_id}, 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("idle_add_in1_kept", r_add_in1, 32'h11);
    chk("idle_add_in2_kept", r_add_in2, 32'h22);

    // Reset in EXEC: the pending response must never appear.
    req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd1;
    #1;
    chk("rm_req0_ready", {31'd0, r_req0_ready}, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    chk("rm_in_exec", {31'd0, r_busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rm_rsp_valid", {31'd0, r_rsp_valid}, 32'd0);
    chk("rm_busy", {31'd0, r_busy}, 32'd0);
    chk("rm_rsp_sum", r_rsp_sum, 32'd0);
    chk("rm_add_in1", r_add_in1, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rm_no_rsp", {31'd0, r_rsp_valid}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
